// File: rtl/pipeline_control_unit.sv
// Pipeline sequencer for the 5-stage MIPS core: gated stage latch enables and flushes,
// run/step execution, load-use stalls, taken-branch flush, HALT drain and an advance-cycle counter.
module pipeline_control_unit #(
  parameter int                   NB_ADDR      = 5,
  parameter int                   NB_OPCODE    = 6,
  parameter int                   NB_CYCLES    = 32,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE  = 6'h3F,
  parameter int                   DRAIN_CYCLES = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_mode,
  input  logic                 i_start,
  input  logic                 i_step,
  input  logic [NB_OPCODE-1:0] i_id_opcode,
  input  logic [NB_ADDR-1:0]   i_id_rs,
  input  logic [NB_ADDR-1:0]   i_id_rt,
  input  logic                 i_ex_mem_read,
  input  logic [NB_ADDR-1:0]   i_ex_rt,
  input  logic                 i_branch_taken,
  output logic                 o_pc_en,
  output logic                 o_if_id_en,
  output logic                 o_id_ex_en,
  output logic                 o_ex_mem_en,
  output logic                 o_mem_wb_en,
  output logic                 o_if_id_flush,
  output logic                 o_id_ex_flush,
  output logic                 o_ex_mem_flush,
  output logic                 o_stall,
  output logic                 o_running,
  output logic                 o_halted,
  output logic [NB_CYCLES-1:0] o_cycle_count
);

  // state     | meaning
  // IDLE      | waiting for i_start
  // RUN       | pipeline advances every cycle
  // STEP_WAIT | pipeline advances once per i_step rising edge
  // DRAIN     | HALT seen in ID, retiring the older instructions
  // HALTED    | HALT retired, frozen until reset
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STEP_WAIT = 3'd2,
    DRAIN     = 3'd3,
    HALTED    = 3'd4
  } state_t;

  localparam int                  NB_DRAIN   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NB_DRAIN-1:0] DRAIN_LAST = NB_DRAIN'(DRAIN_CYCLES - 1);

  state_t              state, state_next;
  logic [NB_DRAIN-1:0] drain_cnt, drain_cnt_next;
  logic                step_q;
  logic                step_rise;
  logic                adv;
  logic                load_use;
  logic                halt_id;

  assign step_rise = i_step & ~step_q;
  assign load_use  = i_ex_mem_read & (i_ex_rt != '0) &
                     ((i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt));
  assign halt_id   = (i_id_opcode == HALT_OPCODE);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= IDLE;
      drain_cnt     <= '0;
      step_q        <= 1'b0;
      o_cycle_count <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
      step_q    <= i_step;
      if (adv && (o_cycle_count != '1)) o_cycle_count <= o_cycle_count + NB_CYCLES'(1);
    end
  end

  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    adv            = 1'b0;
    o_pc_en        = 1'b0;
    o_if_id_en     = 1'b0;
    o_id_ex_en     = 1'b0;
    o_ex_mem_en    = 1'b0;
    o_mem_wb_en    = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_flush = 1'b0;
    o_stall        = 1'b0;
    o_running      = (state == RUN) || (state == STEP_WAIT) || (state == DRAIN);
    o_halted       = (state == HALTED);

    // A mode change costs one non-advancing cycle so the new mode starts cleanly.
    case (state)
      IDLE:      if (i_start) state_next = i_mode ? STEP_WAIT : RUN;
      RUN:       if (i_mode) state_next = STEP_WAIT; else adv = 1'b1;
      STEP_WAIT: if (!i_mode) state_next = RUN; else adv = step_rise;
      DRAIN:     adv = i_mode ? step_rise : 1'b1;
      default:   ;
    endcase

    if (adv) begin
      if (i_branch_taken) begin
        {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en} = 5'b11111;
        {o_if_id_flush, o_id_ex_flush, o_ex_mem_flush}              = 3'b111;
        // The HALT being drained was on the wrong path.
        if (state == DRAIN) begin
          state_next     = i_mode ? STEP_WAIT : RUN;
          drain_cnt_next = '0;
        end
      end else if (state == DRAIN) begin
        {o_id_ex_en, o_ex_mem_en, o_mem_wb_en} = 3'b111;
        o_id_ex_flush                          = 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          state_next     = HALTED;
          drain_cnt_next = '0;
        end else begin
          drain_cnt_next = drain_cnt + NB_DRAIN'(1);
        end
      end else if (load_use) begin
        {o_id_ex_en, o_ex_mem_en, o_mem_wb_en} = 3'b111;
        o_id_ex_flush                          = 1'b1;
        o_stall                                = 1'b1;
      end else begin
        {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en} = 5'b11111;
        if (halt_id) begin
          state_next     = DRAIN;
          drain_cnt_next = '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Self-checking bench for pipeline_control_unit: directed vector table, hand-written
// drain/step/reset/saturation sequences and a randomized run against a reference model.
module tb_pipeline_control_unit;

  localparam int NBC = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mode, start, step, memrd, br;
  logic [5:0]     opcode;
  logic [4:0]     rs, rt, exrt;
  logic           pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic           if_id_flush, id_ex_flush, ex_mem_flush;
  logic           stall, running, halted;
  logic [NBC-1:0] cycle_count;

  pipeline_control_unit #(.NB_CYCLES(NBC)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_mode(mode), .i_start(start), .i_step(step),
    .i_id_opcode(opcode), .i_id_rs(rs), .i_id_rt(rt), .i_ex_mem_read(memrd),
    .i_ex_rt(exrt), .i_branch_taken(br),
    .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_id_ex_en(id_ex_en),
    .o_ex_mem_en(ex_mem_en), .o_mem_wb_en(mem_wb_en),
    .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush), .o_ex_mem_flush(ex_mem_flush),
    .o_stall(stall), .o_running(running), .o_halted(halted), .o_cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // {pc, if_id, id_ex, ex_mem, mem_wb, fl_if_id, fl_id_ex, fl_ex_mem, stall, running, halted}
  localparam logic [10:0] O_IDLE  = 11'b00000_000_0_0_0;
  localparam logic [10:0] O_ADV   = 11'b11111_000_0_1_0;
  localparam logic [10:0] O_HOLD  = 11'b00000_000_0_1_0;
  localparam logic [10:0] O_STALL = 11'b00111_010_1_1_0;
  localparam logic [10:0] O_BR    = 11'b11111_111_0_1_0;
  localparam logic [10:0] O_DRAIN = 11'b00111_010_0_1_0;
  localparam logic [10:0] O_HALT  = 11'b00000_000_0_0_1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        mode, start, step;
    logic [5:0]  op;
    logic [4:0]  rs, rt, exrt;
    logic        memrd, br;
    logic [10:0] exp;
    int          cnt;
  } vec_t;

  vec_t tbl[19];

  function automatic logic [10:0] outs();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_flush, id_ex_flush, ex_mem_flush, stall, running, halted};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    mode = 0; start = 0; step = 0; opcode = 0; rs = 0; rt = 0; exrt = 0; memrd = 0; br = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Reference model: activity flags plus a count of drain advances still owed.
  logic m_active, m_step, m_halted, m_prev_step;
  int   m_drain_left, m_count;

  task automatic m_reset();
    m_active = 0; m_step = 0; m_halted = 0; m_prev_step = 0; m_drain_left = 0; m_count = 0;
  endtask

  function automatic logic m_adv();
    logic rise = step & ~m_prev_step;
    if (!m_active || m_halted) return 1'b0;
    if (m_drain_left > 0) return mode ? rise : 1'b1;
    if (m_step) return mode & rise;
    return !mode;
  endfunction

  function automatic logic m_load_use();
    return memrd && (exrt != 0) && (exrt == rs || exrt == rt);
  endfunction

  function automatic logic [10:0] m_expect();
    logic [1:0] rh = {m_active & ~m_halted, m_halted};
    if (!m_adv())           return {9'b0, rh};
    if (br)                 return {5'b11111, 3'b111, 1'b0, rh};
    if (m_drain_left > 0)   return {5'b00111, 3'b010, 1'b0, rh};
    if (m_load_use())       return {5'b00111, 3'b010, 1'b1, rh};
    return {5'b11111, 3'b000, 1'b0, rh};
  endfunction

  task automatic m_clock();
    logic a = m_adv();
    if (a && m_count < (1 << NBC) - 1) m_count++;
    if (!m_active) begin
      if (start) begin m_active = 1; m_step = mode; end
    end else if (!m_halted) begin
      if (m_drain_left > 0) begin
        if (a && br) begin m_drain_left = 0; m_step = mode; end
        else if (a) begin
          m_drain_left--;
          if (m_drain_left == 0) m_halted = 1;
        end
      end else if (!a) begin
        m_step = mode;
      end else if (!br && !m_load_use() && opcode == 6'h3F) begin
        m_drain_left = 3;
      end
    end
    m_prev_step = step;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_in();
    #2;
    check("reset_out", 32'(outs()), 32'(O_IDLE));
    check("reset_cnt", 32'(cycle_count), 0);
    next();
    rst_n = 1;
    m_reset();
  endtask

  function automatic vec_t mk(input logic md, st, sp, input logic [5:0] op,
                              input logic [4:0] r_s, r_t, e_rt, input logic mr, b,
                              input logic [10:0] e, input int c);
    vec_t v;
    v.mode = md; v.start = st; v.step = sp; v.op = op; v.rs = r_s; v.rt = r_t;
    v.exrt = e_rt; v.memrd = mr; v.br = b; v.exp = e; v.cnt = c;
    return v;
  endfunction

  initial begin
    int advs;
    logic [10:0] e;

    //              md st sp op     rs rt exrt mr br  expected  cnt
    tbl[0]  = mk(0, 1, 0, 6'h00, 0, 0, 0, 0, 0, O_IDLE,  0);
    tbl[1]  = mk(0, 0, 0, 6'h00, 0, 0, 0, 0, 0, O_ADV,   0);
    tbl[2]  = mk(0, 0, 0, 6'h00, 5, 0, 5, 1, 0, O_STALL, 1);
    tbl[3]  = mk(0, 0, 0, 6'h00, 0, 0, 0, 1, 0, O_ADV,   2);
    tbl[4]  = mk(0, 0, 0, 6'h00, 5, 0, 5, 1, 1, O_BR,    3);
    tbl[5]  = mk(0, 0, 0, 6'h00, 1, 7, 7, 1, 0, O_STALL, 4);
    tbl[6]  = mk(1, 0, 0, 6'h00, 0, 0, 0, 0, 0, O_HOLD,  5);
    tbl[7]  = mk(1, 0, 0, 6'h00, 0, 0, 0, 0, 0, O_HOLD,  5);
    tbl[8]  = mk(1, 0, 1, 6'h00, 0, 0, 0, 0, 0, O_ADV,   5);
    tbl[9]  = mk(1, 0, 1, 6'h00, 0, 0, 0, 0, 0, O_HOLD,  6);
    tbl[10] = mk(1, 0, 0, 6'h00, 0, 0, 0, 0, 0, O_HOLD,  6);
    tbl[11] = mk(0, 0, 0, 6'h00, 0, 0, 0, 0, 0, O_HOLD,  6);
    tbl[12] = mk(0, 0, 0, 6'h3F, 3, 0, 3, 1, 0, O_STALL, 6);
    tbl[13] = mk(0, 0, 0, 6'h3F, 0, 0, 0, 0, 0, O_ADV,   7);
    tbl[14] = mk(0, 0, 0, 6'h00, 0, 0, 0, 0, 0, O_DRAIN, 8);
    tbl[15] = mk(0, 0, 0, 6'h00, 0, 0, 0, 0, 0, O_DRAIN, 9);
    tbl[16] = mk(0, 0, 0, 6'h00, 0, 0, 0, 0, 0, O_DRAIN, 10);
    tbl[17] = mk(0, 1, 1, 6'h00, 0, 0, 0, 0, 0, O_HALT,  11);
    tbl[18] = mk(1, 1, 0, 6'h00, 0, 0, 0, 0, 0, O_HALT,  11);

    clear_in();
    do_reset();
    foreach (tbl[i]) begin
      mode = tbl[i].mode; start = tbl[i].start; step = tbl[i].step; opcode = tbl[i].op;
      rs = tbl[i].rs; rt = tbl[i].rt; exrt = tbl[i].exrt; memrd = tbl[i].memrd; br = tbl[i].br;
      #2;
      check($sformatf("vec%0d_out", i), 32'(outs()), 32'(tbl[i].exp));
      check($sformatf("vec%0d_cnt", i), 32'(cycle_count), tbl[i].cnt);
      next();
    end

    // Ten continuous-run cycles.
    do_reset();
    start = 1;
    next();
    start = 0;
    for (int i = 0; i < 10; i++) next();
    check("run10_cnt", 32'(cycle_count), 10);

    // Step mode: a long press counts once, then two short pulses.
    do_reset();
    mode = 1; start = 1;
    next();
    start = 0;
    advs = 0;
    for (int i = 0; i < 12; i++) begin
      step = (i < 5) || (i == 7) || (i == 10);
      #2;
      if (pc_en) advs++;
      next();
    end
    check("step_advs", 32'(advs), 3);
    check("step_cnt", 32'(cycle_count), 3);

    // HALT squashed by a taken branch on the second drain cycle.
    do_reset();
    start = 1;
    next();
    start = 0; opcode = 6'h3F;
    next();
    opcode = 6'h00;
    #2 check("abort_drain1", 32'(outs()), 32'(O_DRAIN));
    next();
    br = 1;
    #2 check("abort_branch", 32'(outs()), 32'(O_BR));
    next();
    br = 0;
    for (int i = 0; i < 4; i++) begin
      #2 check("abort_run", 32'(outs()), 32'(O_ADV));
      next();
    end

    // Asynchronous reset in the middle of a drain.
    opcode = 6'h3F;
    next();
    opcode = 6'h00;
    next();
    rst_n = 0;
    #1;
    check("mid_rst_out", 32'(outs()), 32'(O_IDLE));
    check("mid_rst_cnt", 32'(cycle_count), 0);
    next();
    rst_n = 1;
    #2 check("mid_rst_idle", 32'(outs()), 32'(O_IDLE));
    next();

    // Counter saturation at all-ones.
    do_reset();
    start = 1;
    next();
    start = 0;
    for (int i = 0; i < 300; i++) next();
    check("sat_cnt", 32'(cycle_count), (1 << NBC) - 1);
    check("sat_out", 32'(outs()), 32'(O_ADV));

    // Randomized run against the reference model.
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int c = 0; c < 250; c++) begin
        if ($urandom_range(0, 19) == 0) mode = ~mode;
        start  = ($urandom_range(0, 3) == 0);
        step   = $urandom_range(0, 1);
        opcode = ($urandom_range(0, 11) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
        rs     = 5'($urandom_range(0, 3));
        rt     = 5'($urandom_range(0, 3));
        exrt   = 5'($urandom_range(0, 3));
        memrd  = ($urandom_range(0, 2) == 0);
        br     = ($urandom_range(0, 9) == 0);
        #2;
        e = m_expect();
        check("rand_out", 32'(outs()), 32'(e));
        check("rand_cnt", 32'(cycle_count), 32'(m_count));
        m_clock();
        next();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
